alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue/control front end for the datapath ALU. Accepts one ALU request per handshake (MIPS-style ALUOp, funct, opcode and two operands), decodes it into the 4-bit ALU control code, and drives registered control and operands into the combinational ALU. It holds those inputs stable for a programmable settle time, captures the ALU result, and returns it with zero and illegal flags over a valid/ready response channel. It sits between the multi-cycle control FSM and the ALU.

## Interface
- EXEC_CYCLES, 1: cycles the ALU inputs are held before the result is sampled; legal range 1–15.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- ALU_op  input  2  00 = add, 01 = sub, 10 = R-type (decode funct), 11 = immediate (decode opcode).
- funct  input  6  R-type function field.
- opcode  input  6  instruction opcode.
- operand_a  input  32  first operand.
- operand_b  input  32  second operand.
- ALU_control  output  4  registered control code to the ALU.
- ALU_operand_1  output  32  registered operand to the ALU.
- ALU_operand_2  output  32  registered operand to the ALU.
- ALU_result  input  32  combinational result from the ALU.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  32  captured result; 0 when illegal.
- rsp_zero  output  1  rsp_result == 0.
- rsp_illegal  output  1  request did not decode.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: req_ready = 1. On req_valid && req_ready, load ALU_control, ALU_operand_1 = operand_a and ALU_operand_2 = operand_b. Latch the illegal flag, load the settle counter with EXEC_CYCLES-1, and go to EXEC.
- EXEC: inputs to the ALU stay frozen. The counter decrements once per cycle. In the cycle the counter reads 0, capture rsp_result = illegal ? 0 : ALU_result, rsp_zero and rsp_illegal, then go to DONE.
- DONE: rsp_valid = 1. Response registers are held while rsp_ready = 0. On rsp_ready, go to IDLE.
- Decode for ALU_op = 00: 0010. For ALU_op = 01: 0110.
- Decode for ALU_op = 10, by funct: 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111, 100111 → 1100. Any other funct: illegal, code 0010.
- Decode for ALU_op = 11, by opcode: 001000 → 0010, 001100 → 0000, 001101 → 0001, 001010 → 0111. Any other opcode: illegal, code 0010.
- The block performs no arithmetic. The 32-bit result passes through unchanged; rsp_zero is a 32-bit NOR of the captured value.
- Inputs other than req_valid are ignored outside IDLE.

## Timing
- Reset (asynchronous assert, synchronous release effect): state = IDLE and counter = 0.
- Output values during reset: req_ready = 1, rsp_valid = 0, rsp_result = 0, rsp_zero = 0, rsp_illegal = 0, ALU_control = 0000, ALU_operand_1 = 0, ALU_operand_2 = 0.
- Accept edge = cycle 0. EXEC spans cycles 1..EXEC_CYCLES. rsp_valid is first high in cycle EXEC_CYCLES+1.
- Latency from accept to response is therefore EXEC_CYCLES+1 cycles.
- Response accepted at edge N: req_ready is high in cycle N+1. There is no same-cycle response/request overlap.
- Minimum throughput: one request per EXEC_CYCLES+2 cycles.
- rsp_ready held high before DONE: the response completes in its first valid cycle.
- Reset mid-EXEC or mid-DONE: the operation is abandoned, no response is produced, and all outputs return to their reset values immediately.

## Test plan
- Reset, then ALU_op = 11, opcode = 001000, a = 10, b = 5, EXEC_CYCLES = 1 → ALU_control = 0010 one cycle after accept; rsp_result = 15, rsp_zero = 0, rsp_illegal = 0; rsp_valid 2 cycles after accept.
- ALU_op = 10, funct = 100010, a = b = 0x1234 → ALU_control = 0110, rsp_result = 0, rsp_zero = 1.
- ALU_op = 10, funct = 101010, a = 5, b = 7; then the same with a = 7, b = 5 → ALU_control = 0111; results 1 and 0.
- EXEC_CYCLES = 3, with the ALU model delaying its result by 2 cycles → correct value captured; rsp_valid 4 cycles after accept; operand outputs constant throughout EXEC.
- ALU_op = 10, funct = 000000 → rsp_illegal = 1, rsp_result = 0, rsp_zero = 1. Hold rsp_ready = 0 for 5 cycles → response registers stable, req_ready = 0 throughout.
- Assert rst_n = 0 during EXEC → all outputs reach reset values without a clock edge. After release, a new request completes normally and no stale response appears.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// ----------------------------------------------------------------------------
// Issue/control front end for the combinational datapath ALU.
//
// A request is accepted in IDLE. Its MIPS-style ALUOp/funct/opcode fields are
// decoded into the 4-bit ALU control code. The code and both operands are
// registered and driven into the ALU. They are then held frozen for
// EXEC_CYCLES cycles so the ALU output can settle. At the end of that window
// the ALU result is captured and returned over a valid/ready response channel,
// together with zero and illegal flags.
//
// Parameters
//   EXEC_CYCLES   cycles the ALU inputs are held before sampling (1..15)
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     request present
//   req_ready     block can accept a request (high only in IDLE)
//   ALU_op        00 add, 01 sub, 10 R-type (funct), 11 immediate (opcode)
//   funct         R-type function field
//   opcode        instruction opcode
//   operand_a     first operand
//   operand_b     second operand
//   ALU_control   registered control code to the ALU
//   ALU_operand_1 registered operand to the ALU
//   ALU_operand_2 registered operand to the ALU
//   ALU_result    combinational result from the ALU
//   rsp_valid     response present (high only in DONE)
//   rsp_ready     consumer accepts the response
//   rsp_result    captured result, forced to 0 for illegal requests
//   rsp_zero      rsp_result == 0
//   rsp_illegal   request did not decode
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  ALU_op,
    input  logic [5:0]  funct,
    input  logic [5:0]  opcode,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [3:0]  ALU_control,
    output logic [31:0] ALU_operand_1,
    output logic [31:0] ALU_operand_2,
    input  logic [31:0] ALU_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // ALU control codes
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    // The counter counts down to 0; the capture happens in the cycle it reads 0,
    // so loading EXEC_CYCLES-1 gives exactly EXEC_CYCLES cycles in EXEC.
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state_reg,       state_next;
    logic [3:0]  cnt_reg,         cnt_next;
    logic [3:0]  ctrl_reg,        ctrl_next;
    logic [31:0] op1_reg,         op1_next;
    logic [31:0] op2_reg,         op2_next;
    logic        illegal_reg,     illegal_next;
    logic [31:0] rsp_result_reg,  rsp_result_next;
    logic        rsp_zero_reg,    rsp_zero_next;
    logic        rsp_illegal_reg, rsp_illegal_next;

    logic [3:0]  dec_ctrl;
    logic        dec_illegal;
    logic [31:0] capture_value;

    // ------------------------------------------------------------------------
    // Request decode. Undecodable requests still present a benign ADD code to
    // the ALU; their result is discarded at capture time.
    // ------------------------------------------------------------------------
    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
        case (ALU_op)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: dec_ctrl = CTRL_ADD;
                    6'b100010: dec_ctrl = CTRL_SUB;
                    6'b100100: dec_ctrl = CTRL_AND;
                    6'b100101: dec_ctrl = CTRL_OR;
                    6'b101010: dec_ctrl = CTRL_SLT;
                    6'b100111: dec_ctrl = CTRL_NOR;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: begin
                case (opcode)
                    6'b001000: dec_ctrl = CTRL_ADD;   // addi
                    6'b001100: dec_ctrl = CTRL_AND;   // andi
                    6'b001101: dec_ctrl = CTRL_OR;    // ori
                    6'b001010: dec_ctrl = CTRL_SLT;   // slti
                    default:   dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign capture_value = illegal_reg ? 32'd0 : ALU_result;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        ctrl_next        = ctrl_reg;
        op1_next         = op1_reg;
        op2_next         = op2_reg;
        illegal_next     = illegal_reg;
        rsp_result_next  = rsp_result_reg;
        rsp_zero_next    = rsp_zero_reg;
        rsp_illegal_next = rsp_illegal_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    ctrl_next    = dec_ctrl;
                    op1_next     = operand_a;
                    op2_next     = operand_b;
                    illegal_next = dec_illegal;
                    cnt_next     = CNT_LOAD;
                    state_next   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_reg == 4'd0) begin
                    rsp_result_next  = capture_value;
                    rsp_zero_next    = ~|capture_value;
                    rsp_illegal_next = illegal_reg;
                    state_next       = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            ctrl_reg        <= 4'd0;
            op1_reg         <= 32'd0;
            op2_reg         <= 32'd0;
            illegal_reg     <= 1'b0;
            rsp_result_reg  <= 32'd0;
            rsp_zero_reg    <= 1'b0;
            rsp_illegal_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            ctrl_reg        <= ctrl_next;
            op1_reg         <= op1_next;
            op2_reg         <= op2_next;
            illegal_reg     <= illegal_next;
            rsp_result_reg  <= rsp_result_next;
            rsp_zero_reg    <= rsp_zero_next;
            rsp_illegal_reg <= rsp_illegal_next;
        end
    end

    assign req_ready     = (state_reg == IDLE);
    assign rsp_valid     = (state_reg == DONE);
    assign ALU_control   = ctrl_reg;
    assign ALU_operand_1 = op1_reg;
    assign ALU_operand_2 = op2_reg;
    assign rsp_result    = rsp_result_reg;
    assign rsp_zero      = rsp_zero_reg;
    assign rsp_illegal   = rsp_illegal_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl. Two instances are used: one with
// EXEC_CYCLES = 1 driving a purely combinational ALU model, and one with
// EXEC_CYCLES = 3 driving an ALU model whose result lags its inputs by two
// cycles. Request fields are shared; sel chooses which instance is exercised.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        rsp_ready;
    logic [1:0]  ALU_op;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;

    logic        req_valid_1, req_ready_1, rsp_ready_1, rsp_valid_1, rsp_zero_1, rsp_illegal_1;
    logic [3:0]  ctrl_1;
    logic [31:0] op1_1, op2_1, alu_res_1, rsp_result_1;

    logic        req_valid_3, req_ready_3, rsp_ready_3, rsp_valid_3, rsp_zero_3, rsp_illegal_3;
    logic [3:0]  ctrl_3;
    logic [31:0] op1_3, op2_3, alu_res_3, rsp_result_3;
    logic [31:0] dly1 = 32'd0;
    logic [31:0] dly2 = 32'd0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Reference ALU behaviour
    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_res_1 = alu_f(ctrl_1, op1_1, op2_1);

    always @(posedge clk) begin
        dly1 <= alu_f(ctrl_3, op1_3, op2_3);
        dly2 <= dly1;
    end
    assign alu_res_3 = dly2;

    assign req_valid_1 = req_valid && !sel;
    assign req_valid_3 = req_valid && sel;
    assign rsp_ready_1 = rsp_ready && !sel;
    assign rsp_ready_3 = rsp_ready && sel;

    // Views of the selected instance
    wire        req_ready_s   = sel ? req_ready_3   : req_ready_1;
    wire        rsp_valid_s   = sel ? rsp_valid_3   : rsp_valid_1;
    wire        rsp_zero_s    = sel ? rsp_zero_3    : rsp_zero_1;
    wire        rsp_illegal_s = sel ? rsp_illegal_3 : rsp_illegal_1;
    wire [3:0]  ctrl_s        = sel ? ctrl_3        : ctrl_1;
    wire [31:0] op1_s         = sel ? op1_3         : op1_1;
    wire [31:0] op2_s         = sel ? op2_3         : op2_1;
    wire [31:0] rsp_result_s  = sel ? rsp_result_3  : rsp_result_1;

    alu_issue_ctrl #(.EXEC_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_1), .req_ready(req_ready_1),
        .ALU_op(ALU_op), .funct(funct), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .ALU_control(ctrl_1), .ALU_operand_1(op1_1), .ALU_operand_2(op2_1),
        .ALU_result(alu_res_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_result(rsp_result_1), .rsp_zero(rsp_zero_1), .rsp_illegal(rsp_illegal_1)
    );

    alu_issue_ctrl #(.EXEC_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_3), .req_ready(req_ready_3),
        .ALU_op(ALU_op), .funct(funct), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .ALU_control(ctrl_3), .ALU_operand_1(op1_3), .ALU_operand_2(op2_3),
        .ALU_result(alu_res_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3),
        .rsp_result(rsp_result_3), .rsp_zero(rsp_zero_3), .rsp_illegal(rsp_illegal_3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":req_ready"},   32'(req_ready_s),   32'd1);
        check({tag, ":rsp_valid"},   32'(rsp_valid_s),   32'd0);
        check({tag, ":rsp_result"},  rsp_result_s,       32'd0);
        check({tag, ":rsp_zero"},    32'(rsp_zero_s),    32'd0);
        check({tag, ":rsp_illegal"}, 32'(rsp_illegal_s), 32'd0);
        check({tag, ":ctrl"},        32'(ctrl_s),        32'd0);
        check({tag, ":op1"},         op1_s,              32'd0);
        check({tag, ":op2"},         op2_s,              32'd0);
    endtask

    // One complete request/response transaction on the selected instance.
    // hold = number of DONE cycles with rsp_ready low before accepting.
    task automatic run_req(input string name, input logic [1:0] op, input logic [5:0] fn,
                           input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] ectrl, input logic [31:0] eres,
                           input logic ezero, input logic eill, input int hold);
        int lat;
        int exp_lat;
        exp_lat = sel ? 4 : 2;
        @(negedge clk);
        ALU_op = op; funct = fn; opcode = opc; operand_a = a; operand_b = b;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        check({name, ":req_ready_idle"}, 32'(req_ready_s), 32'd1);
        @(negedge clk);
        // Cycle 1: scramble the request fields; the DUT must ignore them now.
        req_valid = 1'b0;
        ALU_op = ~op; funct = ~fn; opcode = ~opc; operand_a = ~a; operand_b = ~b;
        check({name, ":ctrl"}, 32'(ctrl_s), 32'(ectrl));
        lat = 1;
        while (!rsp_valid_s && lat < 20) begin
            check({name, ":op1_frozen"}, op1_s, a);
            check({name, ":op2_frozen"}, op2_s, b);
            @(negedge clk);
            lat++;
        end
        check({name, ":latency"},     32'(lat),           32'(exp_lat));
        check({name, ":rsp_result"},  rsp_result_s,       eres);
        check({name, ":rsp_zero"},    32'(rsp_zero_s),    32'(ezero));
        check({name, ":rsp_illegal"}, 32'(rsp_illegal_s), 32'(eill));
        check({name, ":req_ready_busy"}, 32'(req_ready_s), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, ":hold_valid"},   32'(rsp_valid_s),   32'd1);
            check({name, ":hold_result"},  rsp_result_s,       eres);
            check({name, ":hold_zero"},    32'(rsp_zero_s),    32'(ezero));
            check({name, ":hold_illegal"}, 32'(rsp_illegal_s), 32'(eill));
            check({name, ":hold_ready"},   32'(req_ready_s),   32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({name, ":post_valid"}, 32'(rsp_valid_s), 32'd0);
        check({name, ":post_ready"}, 32'(req_ready_s), 32'd1);
        $display("txn %s sel=%0d ctrl=%b result=%0h zero=%0d illegal=%0d latency=%0d",
                 name, sel, ctrl_s, rsp_result_s, rsp_zero_s, rsp_illegal_s, lat);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        ALU_op = 2'b00; funct = 6'd0; opcode = 6'd0; operand_a = 32'd0; operand_b = 32'd0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset1");
        sel = 1'b1;
        check_reset_outputs("reset3");
        sel = 1'b0;
        rst_n = 1'b1;

        //      name        op     funct      opcode     a             b             ctrl     result        z  ill hold
        run_req("addi",     2'b11, 6'b000000, 6'b001000, 32'd10,       32'd5,        4'b0010, 32'd15,       0, 0, 0);
        run_req("sub_eq",   2'b10, 6'b100010, 6'b000000, 32'h1234,     32'h1234,     4'b0110, 32'd0,        1, 0, 0);
        run_req("slt_lt",   2'b10, 6'b101010, 6'b000000, 32'd5,        32'd7,        4'b0111, 32'd1,        0, 0, 0);
        run_req("slt_gt",   2'b10, 6'b101010, 6'b000000, 32'd7,        32'd5,        4'b0111, 32'd0,        1, 0, 0);
        run_req("op_add",   2'b00, 6'b111111, 6'b111111, 32'd3,        32'd4,        4'b0010, 32'd7,        0, 0, 0);
        run_req("op_sub",   2'b01, 6'b000000, 6'b000000, 32'd9,        32'd2,        4'b0110, 32'd7,        0, 0, 0);
        run_req("and_r",    2'b10, 6'b100100, 6'b000000, 32'hF0F0,     32'hFF00,     4'b0000, 32'hF000,     0, 0, 0);
        run_req("or_r",     2'b10, 6'b100101, 6'b000000, 32'h0F,       32'hF0,       4'b0001, 32'hFF,       0, 0, 0);
        run_req("nor_r",    2'b10, 6'b100111, 6'b000000, 32'd0,        32'd0,        4'b1100, 32'hFFFF_FFFF,0, 0, 0);
        run_req("ori",      2'b11, 6'b000000, 6'b001101, 32'hF0,       32'h0F,       4'b0001, 32'hFF,       0, 0, 0);
        run_req("slti",     2'b11, 6'b000000, 6'b001010, 32'hFFFF_FFFF,32'd1,        4'b0111, 32'd1,        0, 0, 0);
        run_req("bad_opc",  2'b11, 6'b000000, 6'b000000, 32'd3,        32'd4,        4'b0010, 32'd0,        1, 1, 0);
        run_req("bad_fn",   2'b10, 6'b000000, 6'b000000, 32'd3,        32'd4,        4'b0010, 32'd0,        1, 1, 5);

        // Slow ALU: value only valid in the last EXEC cycle
        sel = 1'b1;
        run_req("slow_add", 2'b11, 6'b000000, 6'b001000, 32'd100,      32'd23,       4'b0010, 32'd123,      0, 0, 0);

        // Asynchronous reset in the middle of EXEC
        @(negedge clk);
        ALU_op = 2'b00; operand_a = 32'd55; operand_b = 32'd66;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_exec:in_exec", 32'(req_ready_s), 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_exec_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst:no_stale_rsp", 32'(rsp_valid_s), 32'd0);
        end
        run_req("post_rst", 2'b11, 6'b000000, 6'b001100, 32'hFF00,     32'h0FF0,     4'b0000, 32'h0F00,     0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
